lbp_stream_engine: RTL and testbench

Parametrised Local Binary Pattern engine for a raster grayscale image of IMG_W x IMG_H pixels. It reads pixels from the gray memory and writes one 8-bit LBP code per interior pixel to the LBP memory. It replaces the fixed 128x128 flow with:
- a sliding 3x3 window (3 fetches per pixel after each row start),
- stall support on gray_ready,
- optional zero-fill of border pixels.
It sits between the gray image ROM and the LBP result RAM at the top of the LBP subsystem.

---
 rtl/lbp_stream_engine.sv | 213 +++++++++++++++++++++
 tb/tb_lbp_stream_engine.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lbp_stream_engine.sv
// lbp_stream_engine
//   Streams a raster grayscale image out of the gray ROM, computes an 8-bit
//   Local Binary Pattern code for each interior pixel using a sliding 3x3
//   window, and writes the codes to the LBP RAM in raster order.
//   Optionally zero-fills the border pixels after the interior pass.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous active-high reset
//   gray_addr    pixel read address (row*IMG_W+col)
//   gray_req     read strobe, only asserted while gray_ready is high
//   gray_ready   memory ready; low stalls the fetch sequence
//   gray_data    read data, valid the cycle after an accepted request
//   lbp_addr     LBP write address
//   lbp_valid    one-cycle write strobe
//   lbp_data     LBP code (0x00 for border fill)
//   finish       frame complete, sticky until reset
module lbp_stream_engine #(
   parameter int IMG_W       = 128,
   parameter int IMG_H       = 128,
   parameter int AW          = 14,
   parameter int DW          = 8,
   parameter int BORDER_ZERO = 0
) (
   input  logic          clk,
   input  logic          reset,
   output logic [AW-1:0] gray_addr,
   output logic          gray_req,
   input  logic          gray_ready,
   input  logic [DW-1:0] gray_data,
   output logic [AW-1:0] lbp_addr,
   output logic          lbp_valid,
   output logic [7:0]    lbp_data,
   output logic          finish
);

   typedef enum logic [2:0] {IDLE, FILL, SLIDE, WRITE, BORDER, DONE} state_t;

   localparam logic [AW-1:0] W_C   = AW'(IMG_W);
   localparam logic [AW-1:0] W_M1  = AW'(IMG_W - 1);
   localparam logic [AW-1:0] W_M2  = AW'(IMG_W - 2);
   localparam logic [AW-1:0] W_P1  = AW'(IMG_W + 1);
   localparam logic [AW-1:0] W2_M1 = AW'(2 * IMG_W - 1);
   localparam logic [AW-1:0] H_M1  = AW'(IMG_H - 1);
   localparam logic [AW-1:0] H_M2  = AW'(IMG_H - 2);

   // Window is stored column-major (index = col*3 + row), matching the fetch
   // order, so every captured pixel simply shifts in at index 8. Three
   // captures during SLIDE therefore move the window left by one column.
   localparam int NB_IDX [8] = '{0, 3, 6, 1, 7, 2, 5, 8};

   state_t        state_q;
   logic [AW-1:0] faddr_q;     // address of the next pending fetch
   logic [AW-1:0] caddr_q;     // address of the current center pixel
   logic [AW-1:0] col_q;
   logic [AW-1:0] row_q;
   logic [AW-1:0] baddr_q;
   logic [AW-1:0] bcol_q;
   logic [AW-1:0] brow_q;
   logic [1:0]    frow_q;      // row within the column being fetched
   logic [3:0]    fcnt_q;      // accepted fetches in this FILL/SLIDE
   logic          acc_q;       // a request was accepted last cycle
   logic [DW-1:0] win_q [9];
   logic [DW-1:0] win_d [9];
   logic [AW-1:0] lbp_addr_q;
   logic          lbp_valid_q;
   logic [7:0]    lbp_data_q;
   logic          finish_q;

   logic          fetching;
   logic          fetch_req;
   logic          frame_fetched;
   logic [3:0]    fetch_total;
   logic [7:0]    code_d;

   always_comb begin
      fetching      = (state_q == FILL) || (state_q == SLIDE);
      fetch_total   = (state_q == FILL) ? 4'd9 : 4'd3;
      fetch_req     = fetching && (fcnt_q < fetch_total) && gray_ready;
      // Last data word is on gray_data this cycle.
      frame_fetched = fetching && (fcnt_q == fetch_total) && acc_q;
      win_d = win_q;
      if (acc_q) begin
         for (int i = 0; i < 8; i++) begin
            win_d[i] = win_q[i + 1];
         end
         win_d[8] = gray_data;
      end
   end

   // Code is taken from the window including the word being captured, so
   // the write registers are loaded in the same cycle as the final capture.
   genvar gi;
   generate
      for (gi = 0; gi < 8; gi++) begin : g_code
         assign code_d[gi] = (win_d[NB_IDX[gi]] >= win_d[4]);
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         faddr_q     <= '0;
         caddr_q     <= '0;
         col_q       <= '0;
         row_q       <= '0;
         baddr_q     <= '0;
         bcol_q      <= '0;
         brow_q      <= '0;
         frow_q      <= '0;
         fcnt_q      <= '0;
         acc_q       <= 1'b0;
         win_q       <= '{default: '0};
         lbp_addr_q  <= '0;
         lbp_valid_q <= 1'b0;
         lbp_data_q  <= '0;
         finish_q    <= 1'b0;
      end else begin
         acc_q <= fetch_req;
         win_q <= win_d;

         // Column-major walk: down one row, or back to the top of the next
         // column. After the last fetch of a column group the pointer lands
         // on (r-1, c+2), which is also the first fetch of both the next
         // SLIDE and the next row's FILL, so no reload is needed.
         if (fetch_req) begin
            fcnt_q <= fcnt_q + 4'd1;
            if (frow_q == 2'd2) begin
               frow_q  <= 2'd0;
               faddr_q <= faddr_q - W2_M1;
            end else begin
               frow_q  <= frow_q + 2'd1;
               faddr_q <= faddr_q + W_C;
            end
         end

         case (state_q)
            IDLE: begin
               if (gray_ready) begin
                  state_q <= FILL;
                  caddr_q <= W_P1;
                  col_q   <= AW'(1);
                  row_q   <= AW'(1);
               end
            end
            FILL, SLIDE: begin
               if (frame_fetched) begin
                  state_q     <= WRITE;
                  fcnt_q      <= '0;
                  lbp_valid_q <= 1'b1;
                  lbp_addr_q  <= caddr_q;
                  lbp_data_q  <= code_d;
               end
            end
            WRITE: begin
               lbp_valid_q <= 1'b0;
               if (col_q < W_M2) begin
                  state_q <= SLIDE;
                  col_q   <= col_q + AW'(1);
                  caddr_q <= caddr_q + AW'(1);
               end else if (row_q < H_M2) begin
                  state_q <= FILL;
                  row_q   <= row_q + AW'(1);
                  col_q   <= AW'(1);
                  caddr_q <= caddr_q + AW'(3);
               end else if (BORDER_ZERO != 0) begin
                  state_q <= BORDER;
                  baddr_q <= '0;
                  bcol_q  <= '0;
                  brow_q  <= '0;
               end else begin
                  state_q  <= DONE;
                  finish_q <= 1'b1;
               end
            end
            BORDER: begin
               lbp_valid_q <= 1'b1;
               lbp_addr_q  <= baddr_q;
               lbp_data_q  <= 8'h00;
               if (bcol_q == W_M1) begin
                  if (brow_q == H_M1) begin
                     state_q <= DONE;
                  end else begin
                     brow_q  <= brow_q + AW'(1);
                     bcol_q  <= '0;
                     baddr_q <= baddr_q + AW'(1);
                  end
               end else if ((brow_q == '0) || (brow_q == H_M1)) begin
                  bcol_q  <= bcol_q + AW'(1);
                  baddr_q <= baddr_q + AW'(1);
               end else begin
                  // Middle rows: jump from the left edge to the right edge.
                  bcol_q  <= W_M1;
                  baddr_q <= baddr_q + W_M1;
               end
            end
            DONE: begin
               lbp_valid_q <= 1'b0;
               finish_q    <= 1'b1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gray_addr = faddr_q;
   assign gray_req  = fetch_req;
   assign lbp_addr  = lbp_addr_q;
   assign lbp_valid = lbp_valid_q;
   assign lbp_data  = lbp_data_q;
   assign finish    = finish_q;

endmodule

// File: tb/tb_lbp_stream_engine.sv
// Testbench for lbp_stream_engine: three concurrently running instances
// (3x3, 4x4, 5x4 with border fill), each fed from its own image memory and
// checked against a pixel-level LBP model through a write scoreboard.
module tb_lbp_stream_engine;

   localparam int NCFG = 3;
   localparam int CFG_W  [NCFG] = '{3, 4, 5};
   localparam int CFG_H  [NCFG] = '{3, 4, 4};
   localparam int CFG_BZ [NCFG] = '{0, 0, 1};
   localparam int DR [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
   localparam int DC [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};

   typedef struct packed {
      logic [13:0] a;
      logic [7:0]  d;
   } wr_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit done_flag [NCFG];

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp, input int inst);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got 0x%0h, expected 0x%0h", name, inst, act, exp);
      end
   endtask

   genvar gi;
   generate
      for (gi = 0; gi < NCFG; gi++) begin : g_cfg
         localparam int W  = CFG_W[gi];
         localparam int H  = CFG_H[gi];
         localparam int BZ = CFG_BZ[gi];
         localparam int N  = W * H;

         logic        reset = 1'b1;
         logic        gray_ready = 1'b0;
         logic [7:0]  gray_data = 8'h00;
         logic [13:0] gray_addr;
         logic        gray_req;
         logic [13:0] lbp_addr;
         logic        lbp_valid;
         logic [7:0]  lbp_data;
         logic        finish;
         logic [7:0]  mem [N];
         wr_t         sb [$];
         int          reads = 0;

         lbp_stream_engine #(
            .IMG_W(W), .IMG_H(H), .AW(14), .DW(8), .BORDER_ZERO(BZ)
         ) u_dut (
            .clk(clk), .reset(reset),
            .gray_addr(gray_addr), .gray_req(gray_req),
            .gray_ready(gray_ready), .gray_data(gray_data),
            .lbp_addr(lbp_addr), .lbp_valid(lbp_valid),
            .lbp_data(lbp_data), .finish(finish)
         );

         // Gray ROM: data appears the cycle after an accepted request.
         always @(posedge clk) begin
            if (gray_req) gray_data <= mem[gray_addr];
         end

         // Monitor: read protocol and scoreboard compare.
         always @(negedge clk) begin : mon
            wr_t m;
            if (!reset) begin
               if (gray_req) begin
                  reads++;
                  check("req_needs_ready", 64'(gray_ready), 64'd1, gi);
               end
               if (lbp_valid) begin
                  $display("inst%0d write addr=%0d data=0x%02h", gi, lbp_addr, lbp_data);
                  if (sb.size() == 0) begin
                     n_checks++;
                     n_fail++;
                     $display("FAIL unexpected_write inst%0d: got addr %0d, expected no write", gi, lbp_addr);
                  end else begin
                     m = sb.pop_front();
                     check("lbp_addr", 64'(lbp_addr), 64'(m.a), gi);
                     check("lbp_data", 64'(lbp_data), 64'(m.d), gi);
                  end
               end
            end
         end

         // Driver: six frames per instance, model pushed at each frame start.
         initial begin : drv
            int   cyc, last_wr, seen, target, base, n_int, row, col;
            bit   stall_en, mid_en, restart;
            logic [7:0] code, ctr;
            wr_t  e;
            n_int  = (W - 2) * (H - 2);
            target = (n_int >= 2) ? 2 : 1;
            for (int sc = 0; sc < 6; sc++) begin
               for (int a = 0; a < N; a++) begin
                  row = a / W;
                  col = a % W;
                  case (sc)
                     0:       mem[a] = 8'(a + 1);
                     1:       mem[a] = 8'h80;
                     2, 3:    mem[a] = (row > 0 && row < H-1 && col > 0 && col < W-1) ? 8'hFF : 8'h00;
                     4:       mem[a] = 8'($urandom_range(0, 3) * 64);
                     default: mem[a] = 8'($urandom_range(0, 255));
                  endcase
               end
               stall_en = (sc >= 3);
               mid_en   = (sc == 5);

               @(posedge clk);
               #1 reset = 1'b1;
               gray_ready = 1'b0;
               #1 check("reset_outputs",
                        64'({gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish}), 64'd0, gi);

               restart = 1'b1;
               while (restart) begin
                  restart = 1'b0;
                  sb.delete();
                  for (int r = 1; r < H - 1; r++) begin
                     for (int c = 1; c < W - 1; c++) begin
                        ctr  = mem[r * W + c];
                        code = 8'h00;
                        for (int k = 0; k < 8; k++) begin
                           if (mem[(r + DR[k]) * W + (c + DC[k])] >= ctr) code[k] = 1'b1;
                        end
                        e.a = 14'(r * W + c);
                        e.d = code;
                        sb.push_back(e);
                     end
                  end
                  if (BZ != 0) begin
                     for (int a = 0; a < N; a++) begin
                        if (a < W || a >= N - W || a % W == 0 || a % W == W - 1) begin
                           e.a = 14'(a);
                           e.d = 8'h00;
                           sb.push_back(e);
                        end
                     end
                  end
                  base    = reads;
                  cyc     = 0;
                  last_wr = -1;
                  seen    = 0;
                  @(posedge clk);
                  #1 reset = 1'b0;
                  gray_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                  while (!finish && cyc < 4000 && !restart) begin
                     @(posedge clk);
                     #1 cyc++;
                     gray_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
                     if (lbp_valid) begin
                        last_wr = cyc;
                        seen++;
                     end
                     if (mid_en && lbp_valid && seen == target) begin
                        reset = 1'b1;
                        #1 check("midframe_reset_outputs",
                                 64'({gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish}), 64'd0, gi);
                        mid_en  = 1'b0;
                        restart = 1'b1;
                     end
                  end
               end

               check("finish_before_timeout", 64'(finish), 64'd1, gi);
               check("finish_latency", 64'(cyc), 64'(last_wr + 1), gi);
               check("pending_writes", 64'(sb.size()), 64'd0, gi);
               check("gray_read_count", 64'(reads - base), 64'((H - 2) * (9 + 3 * (W - 3))), gi);
               gray_ready = 1'b1;
               repeat (3) begin
                  @(posedge clk);
                  #1 check("done_quiet", 64'({finish, lbp_valid, gray_req}), 64'b100, gi);
               end
            end
            done_flag[gi] = 1'b1;
         end
      end
   endgenerate

   initial begin : summary
      int waited;
      bit all_done;
      waited   = 0;
      all_done = 1'b0;
      while (!all_done && waited < 60000) begin
         @(posedge clk);
         waited++;
         all_done = 1'b1;
         for (int i = 0; i < NCFG; i++) all_done &= done_flag[i];
      end
      if (!all_done) begin
         n_checks++;
         n_fail++;
         $display("FAIL global_timeout: got %0d cycles, expected all instances done", waited);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
